// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 16-bit RISC pipeline controller:
//   - major opcodes used by the hazard/sequencing logic (id_ir/ex_ir[15:12])
//   - the NOP instruction encoding
//   - the LM/SM sequencer state type
//   - a small opcode classification helper
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [3:0]  OP_LW  = 4'b0100;
    localparam logic [3:0]  OP_SW  = 4'b0101;
    localparam logic [3:0]  OP_LM  = 4'b0110;
    localparam logic [3:0]  OP_SM  = 4'b0111;

    // ADD R0,R0,R0 with no flag update: architecturally a no-op.
    localparam logic [15:0] NOP_IR = 16'h0000;

    // Width of a register index (R0..R7).
    localparam int          REG_IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } lmsm_state_t;

    // True for the load/store-multiple opcodes that need micro-op sequencing.
    function automatic logic is_lmsm(input logic [3:0] op);
        return (op == OP_LM) || (op == OP_SM);
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// -----------------------------------------------------------------------------
// lsb_prio_enc
// Lowest-set-bit priority encoder for the LM/SM register mask.
// Ports:
//   mask_i  in  W      mask to scan (bit 0 has highest priority)
//   idx_o   out IDX_W  index of the lowest set bit (0 when none set)
//   found_o out 1      at least one bit of mask_i is set
//   rem_o   out W      mask_i with the reported bit cleared
// -----------------------------------------------------------------------------
module lsb_prio_enc #(
    parameter int W     = 8,
    parameter int IDX_W = 3
) (
    input  logic [W-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o,
    output logic [W-1:0]     rem_o
);

    // Scan upward; the first set bit wins and is removed from the remainder.
    always_comb begin
        idx_o   = {IDX_W{1'b0}};
        found_o = 1'b0;
        rem_o   = mask_i;
        for (int i = 0; i < W; i++) begin
            if (!found_o && mask_i[i]) begin
                idx_o    = IDX_W'(i);
                found_o  = 1'b1;
                rem_o[i] = 1'b0;
            end else begin
                found_o  = found_o;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central pipeline controller: derives EN/CLR for every pipeline register from
// memory stall, EX redirect and load-use conditions, and sequences LM/SM
// instructions held in ID into one micro-op per mask bit.
//
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN
//   defined   -> saturating 16-bit stall/flush performance counters
//   undefined -> stall_cnt/flush_cnt tied to 0, no counter flops
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_ir, ex_ir             instructions in IF_ID and RR_EX
//   ex_dest                  destination register of the EX instruction
//   rr_src_a/b(_vld)         RR-stage source registers and read flags
//   ex_redirect, mem_stall   EX branch/jump taken, data memory not ready
//   *_en, *_clr              pipeline register enables / clears
//   uop_valid/reg/offset     LM/SM micro-op issued into ID_RR
//   lmsm_busy                sequencer is in SEQ
//   stall_cnt, flush_cnt     performance counters
//
// Priority: rst > mem_stall > ex_redirect > load-use > LM/SM > normal.
// All control outputs are Mealy: registered sequencer state + current inputs.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MASK_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          id_ir,
    input  logic [15:0]          ex_ir,
    input  logic [2:0]           ex_dest,
    input  logic [2:0]           rr_src_a,
    input  logic [2:0]           rr_src_b,
    input  logic                 rr_src_a_vld,
    input  logic                 rr_src_b_vld,
    input  logic                 ex_redirect,
    input  logic                 mem_stall,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_rr_en,
    output logic                 rr_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_clr,
    output logic                 id_rr_clr,
    output logic                 rr_ex_clr,
    output logic                 ex_mem_clr,
    output logic                 mem_wb_clr,
    output logic                 uop_valid,
    output logic [REG_IDX_W-1:0] uop_reg,
    output logic [15:0]          uop_offset,
    output logic                 lmsm_busy,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          flush_cnt
);

    lmsm_state_t         state_q, state_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [15:0]         offset_q, offset_d;

    logic                load_use_s;
    logic                is_lmsm_s;
    logic                redirect_taken_s;

    logic [MASK_W-1:0]   enc_mask_s;
    logic [REG_IDX_W-1:0] enc_idx_s;
    logic                enc_found_s;
    logic [MASK_W-1:0]   enc_rem_s;

    assign load_use_s = (ex_ir[15:12] == OP_LW) &&
                        ((rr_src_a_vld && (rr_src_a == ex_dest)) ||
                         (rr_src_b_vld && (rr_src_b == ex_dest)));

    assign is_lmsm_s  = is_lmsm(id_ir[15:12]);

    // In SEQ the stored remainder is scanned; in IDLE the mask straight from ID,
    // so the first micro-op issues in the same cycle the instruction arrives.
    assign enc_mask_s = (state_q == SEQ) ? mask_q : id_ir[MASK_W-1:0];

    lsb_prio_enc #(
        .W     (MASK_W),
        .IDX_W (REG_IDX_W)
    ) u_enc (
        .mask_i  (enc_mask_s),
        .idx_o   (enc_idx_s),
        .found_o (enc_found_s),
        .rem_o   (enc_rem_s)
    );

    assign lmsm_busy = (state_q == SEQ) && !rst;

    // Pipeline control and sequencer next state, evaluated in priority order.
    always_comb begin
        pc_en            = 1'b1;
        if_id_en         = 1'b1;
        id_rr_en         = 1'b1;
        rr_ex_en         = 1'b1;
        ex_mem_en        = 1'b1;
        mem_wb_en        = 1'b1;
        if_id_clr        = 1'b0;
        id_rr_clr        = 1'b0;
        rr_ex_clr        = 1'b0;
        ex_mem_clr       = 1'b0;
        mem_wb_clr       = 1'b0;
        uop_valid        = 1'b0;
        uop_reg          = enc_idx_s;
        uop_offset       = 16'h0000;
        redirect_taken_s = 1'b0;
        state_d          = state_q;
        mask_d           = mask_q;
        offset_d         = offset_q;

        if (state_q == SEQ) begin
            uop_offset = offset_q;
        end else begin
            uop_offset = 16'h0000;
        end

        if (rst) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_rr_en   = 1'b0;
            rr_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_en  = 1'b0;
            if_id_clr  = 1'b1;
            id_rr_clr  = 1'b1;
            rr_ex_clr  = 1'b1;
            ex_mem_clr = 1'b1;
            mem_wb_clr = 1'b1;
            state_d    = IDLE;
            mask_d     = {MASK_W{1'b0}};
            offset_d   = 16'h0000;
        end else if (mem_stall) begin
            // Everything upstream of MEM holds; a bubble goes into MEM_WB.
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_rr_en   = 1'b0;
            rr_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_clr = 1'b1;
        end else if (ex_redirect) begin
            // Squash the three younger stages, including any in-flight micro-op.
            if_id_clr        = 1'b1;
            id_rr_clr        = 1'b1;
            rr_ex_clr        = 1'b1;
            redirect_taken_s = 1'b1;
            state_d          = IDLE;
            mask_d           = {MASK_W{1'b0}};
            offset_d         = 16'h0000;
        end else if (load_use_s) begin
            // Hold the RR instruction one cycle and push a bubble into EX.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_rr_en  = 1'b0;
            rr_ex_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_lmsm_s) begin
                        if (!enc_found_s) begin
                            id_rr_clr = 1'b1;
                        end else begin
                            uop_valid = 1'b1;
                            if (enc_rem_s != {MASK_W{1'b0}}) begin
                                mask_d   = enc_rem_s;
                                offset_d = 16'd2;
                                state_d  = SEQ;
                                pc_en    = 1'b0;
                                if_id_en = 1'b0;
                            end else begin
                                state_d  = IDLE;
                            end
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                SEQ: begin
                    if (enc_found_s) begin
                        uop_valid = 1'b1;
                        mask_d    = enc_rem_s;
                        if (enc_rem_s == {MASK_W{1'b0}}) begin
                            // Last bit: release fetch and leave SEQ.
                            offset_d = 16'h0000;
                            state_d  = IDLE;
                        end else begin
                            offset_d = offset_q + 16'd2;
                            pc_en    = 1'b0;
                            if_id_en = 1'b0;
                        end
                    end else begin
                        // Empty stored mask cannot normally occur; recover.
                        offset_d = 16'h0000;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    mask_d   = {MASK_W{1'b0}};
                    offset_d = 16'h0000;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    // Sequencer state register; freezes are expressed by *_d holding *_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mask_q   <= {MASK_W{1'b0}};
            offset_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            offset_q <= offset_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counters of front-end stall cycles and honoured redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (redirect_taken_s && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    logic unused_s;
    assign unused_s = ^{id_ir[11:MASK_W], ex_ir[11:0]};
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;

    logic unused_s;
    assign unused_s = ^{id_ir[11:MASK_W], ex_ir[11:0], redirect_taken_s};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed stimulus for pipe_hazard_ctrl. A behavioural model keeps the list of
// micro-ops still owed by an LM/SM instruction and derives the expected
// controls each cycle from the priority rules; hand-written literal checks in
// the stimulus pin the model to known sequences.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] id_ir, ex_ir;
    logic [2:0]  ex_dest, rr_src_a, rr_src_b;
    logic        rr_src_a_vld, rr_src_b_vld, ex_redirect, mem_stall;
    logic        pc_en, if_id_en, id_rr_en, rr_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_clr, id_rr_clr, rr_ex_clr, ex_mem_clr, mem_wb_clr;
    logic        uop_valid, lmsm_busy;
    logic [2:0]  uop_reg;
    logic [15:0] uop_offset, stall_cnt, flush_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;

    pipe_hazard_ctrl #(.MASK_W(8)) dut (
        .clk(clk), .rst(rst), .id_ir(id_ir), .ex_ir(ex_ir), .ex_dest(ex_dest),
        .rr_src_a(rr_src_a), .rr_src_b(rr_src_b),
        .rr_src_a_vld(rr_src_a_vld), .rr_src_b_vld(rr_src_b_vld),
        .ex_redirect(ex_redirect), .mem_stall(mem_stall),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_rr_en(id_rr_en),
        .rr_ex_en(rr_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_clr(if_id_clr), .id_rr_clr(id_rr_clr), .rr_ex_clr(rr_ex_clr),
        .ex_mem_clr(ex_mem_clr), .mem_wb_clr(mem_wb_clr),
        .uop_valid(uop_valid), .uop_reg(uop_reg), .uop_offset(uop_offset),
        .lmsm_busy(lmsm_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int          owed[$];      // register indices still to be issued
    int          issued;       // micro-ops already issued for this instruction
    int          m_stall, m_flush;
    logic [5:0]  e_en;         // {pc, if_id, id_rr, rr_ex, ex_mem, mem_wb}
    logic [4:0]  e_clr;        // {if_id, id_rr, rr_ex, ex_mem, mem_wb}
    logic        e_v, e_busy, lu;
    int          e_reg, e_off;
    int          lst[$];

    always @(negedge clk) begin
        e_v   = 1'b0;
        e_reg = -1;
        e_off = 0;
        e_en  = 6'h3F;
        e_clr = 5'h00;
        e_busy = (owed.size() > 0) && !rst;
        lu = (ex_ir[15:12] == 4'b0100) &&
             ((rr_src_a_vld && rr_src_a == ex_dest) || (rr_src_b_vld && rr_src_b == ex_dest));
        if (e_busy) e_reg = owed[0];

        if (rst) begin
            e_en  = 6'h00;
            e_clr = 5'h1F;
        end else if (mem_stall) begin
            e_en  = 6'b000001;
            e_clr = 5'b00001;
        end else if (ex_redirect) begin
            e_clr = 5'b11100;
        end else if (lu) begin
            e_en  = 6'b000111;
            e_clr = 5'b00100;
        end else if (e_busy) begin
            e_v   = 1'b1;
            e_off = 2 * issued;
            if (owed.size() > 1) e_en[5:4] = 2'b00;
        end else if (id_ir[15:12] == 4'b0110 || id_ir[15:12] == 4'b0111) begin
            lst.delete();
            for (int i = 0; i < 8; i++) if (id_ir[i]) lst.push_back(i);
            if (lst.size() == 0) begin
                e_clr[3] = 1'b1;
            end else begin
                e_v   = 1'b1;
                e_reg = lst[0];
                e_off = 0;
                if (lst.size() > 1) e_en[5:4] = 2'b00;
            end
        end

        chk("enables", {26'd0, pc_en, if_id_en, id_rr_en, rr_ex_en, ex_mem_en, mem_wb_en}, {26'd0, e_en});
        chk("clears", {27'd0, if_id_clr, id_rr_clr, rr_ex_clr, ex_mem_clr, mem_wb_clr}, {27'd0, e_clr});
        chk("uop_valid", {31'd0, uop_valid}, {31'd0, e_v});
        chk("lmsm_busy", {31'd0, lmsm_busy}, {31'd0, e_busy});
        if (e_reg >= 0) chk("uop_reg", {29'd0, uop_reg}, e_reg);
        if (e_v) chk("uop_offset", {16'd0, uop_offset}, e_off);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
        chk("flush_cnt", {16'd0, flush_cnt}, m_flush);
`else
        chk("stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("flush_cnt", {16'd0, flush_cnt}, 32'd0);
`endif

        // advance the model to the state after the coming clock edge
        if (rst) begin
            owed.delete();
            issued  = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!e_en[5] && m_stall < 65535) m_stall++;
            if (!mem_stall && ex_redirect) begin
                if (m_flush < 65535) m_flush++;
                owed.delete();
                issued = 0;
            end else if (!mem_stall && !lu && e_v) begin
                if (e_busy) begin
                    void'(owed.pop_front());
                    issued++;
                end else begin
                    for (int i = 1; i < lst.size(); i++) owed.push_back(lst[i]);
                    issued = 1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic neutral();
        id_ir = 16'h0000; ex_ir = 16'h0000; ex_dest = 3'd0;
        rr_src_a = 3'd0; rr_src_b = 3'd0; rr_src_a_vld = 1'b0; rr_src_b_vld = 1'b0;
        ex_redirect = 1'b0; mem_stall = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        neutral();

        // reset held two cycles
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst pc_en", {31'd0, pc_en}, 32'd0);
            chk("rst mem_wb_clr", {31'd0, mem_wb_clr}, 32'd1);
            chk("rst uop_valid", {31'd0, uop_valid}, 32'd0);
            next();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst en", {26'd0, pc_en, if_id_en, id_rr_en, rr_ex_en, ex_mem_en, mem_wb_en}, 32'h3F);
        chk("post-rst if_id_clr", {31'd0, if_id_clr}, 32'd0);
        next();

        // load-use on source A
        ex_ir = 16'h4A40; ex_dest = 3'd5; rr_src_a = 3'd5; rr_src_a_vld = 1'b1;
        @(negedge clk);
        chk("lu pc_en", {31'd0, pc_en}, 32'd0);
        chk("lu id_rr_en", {31'd0, id_rr_en}, 32'd0);
        chk("lu rr_ex_clr", {31'd0, rr_ex_clr}, 32'd1);
        next();
        neutral();
        @(negedge clk);
        chk("lu resume pc_en", {31'd0, pc_en}, 32'd1);
        next();
        // LW with matching but unread source, then SW with match: no hazard
        ex_ir = 16'h4A40; ex_dest = 3'd3; rr_src_b = 3'd3; rr_src_b_vld = 1'b0;
        @(negedge clk); chk("no-lu vld pc_en", {31'd0, pc_en}, 32'd1); next();
        ex_ir = 16'h5A40; rr_src_b_vld = 1'b1;
        @(negedge clk); chk("no-lu sw pc_en", {31'd0, pc_en}, 32'd1); next();
        // load-use on source B
        ex_ir = 16'h4A40;
        @(negedge clk); chk("lu-b rr_ex_clr", {31'd0, rr_ex_clr}, 32'd1); next();
        neutral();

        // LM mask 1010_0100 -> R2,R5,R7 at 0,2,4
        id_ir = 16'h60A4;
        @(negedge clk);
        chk("lm1 reg", {29'd0, uop_reg}, 32'd2);
        chk("lm1 off", {16'd0, uop_offset}, 32'd0);
        chk("lm1 pc_en", {31'd0, pc_en}, 32'd0);
        next();
        @(negedge clk);
        chk("lm2 reg", {29'd0, uop_reg}, 32'd5);
        chk("lm2 off", {16'd0, uop_offset}, 32'd2);
        chk("lm2 pc_en", {31'd0, pc_en}, 32'd0);
        next();
        @(negedge clk);
        chk("lm3 reg", {29'd0, uop_reg}, 32'd7);
        chk("lm3 off", {16'd0, uop_offset}, 32'd4);
        chk("lm3 pc_en", {31'd0, pc_en}, 32'd1);
        next();
        id_ir = 16'h0000;
        @(negedge clk); chk("lm done busy", {31'd0, lmsm_busy}, 32'd0); next();

        // SM with zero mask passes as NOP; single-bit LM issues without stall
        id_ir = 16'h7000;
        @(negedge clk);
        chk("sm0 id_rr_clr", {31'd0, id_rr_clr}, 32'd1);
        chk("sm0 pc_en", {31'd0, pc_en}, 32'd1);
        next();
        id_ir = 16'h6010;
        @(negedge clk);
        chk("lm1bit reg", {29'd0, uop_reg}, 32'd4);
        chk("lm1bit pc_en", {31'd0, pc_en}, 32'd1);
        next();
        id_ir = 16'h0000;
        next();

        // LM 0xFF aborted by redirect in third issue cycle
        id_ir = 16'h60FF;
        next(); next();
        ex_redirect = 1'b1;
        @(negedge clk);
        chk("redir clr3", {29'd0, if_id_clr, id_rr_clr, rr_ex_clr}, 32'h7);
        chk("redir uop_valid", {31'd0, uop_valid}, 32'd0);
        next();
        neutral();
        @(negedge clk); chk("redir busy", {31'd0, lmsm_busy}, 32'd0); next();

        // mem_stall mid-SEQ, mask 0000_0011
        id_ir = 16'h6003;
        next();
        mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mstall mem_wb_clr", {31'd0, mem_wb_clr}, 32'd1);
            chk("mstall uop_reg", {29'd0, uop_reg}, 32'd1);
            next();
        end
        mem_stall = 1'b0;
        @(negedge clk);
        chk("mstall issue reg", {29'd0, uop_reg}, 32'd1);
        chk("mstall issue valid", {31'd0, uop_valid}, 32'd1);
        chk("mstall issue off", {16'd0, uop_offset}, 32'd2);
        next();
        id_ir = 16'h0000;
        @(negedge clk); chk("mstall busy", {31'd0, lmsm_busy}, 32'd0); next();

        // redirect in the last SEQ issue
        id_ir = 16'h6003;
        next();
        ex_redirect = 1'b1;
        @(negedge clk);
        chk("redir-last id_rr_clr", {31'd0, id_rr_clr}, 32'd1);
        chk("redir-last valid", {31'd0, uop_valid}, 32'd0);
        next();
        neutral();
        next();

        // load-use during SEQ freezes, then rst mid-SEQ discards the mask
        id_ir = 16'h60F0;
        next();
        ex_ir = 16'h4A40; ex_dest = 3'd1; rr_src_a = 3'd1; rr_src_a_vld = 1'b1;
        next();
        ex_ir = 16'h0000; rr_src_a_vld = 1'b0;
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        id_ir = 16'h0000;
        @(negedge clk); chk("rst-seq busy", {31'd0, lmsm_busy}, 32'd0); next();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        mem_stall = 1'b1;
        for (int c = 0; c < 70000; c++) next();
        mem_stall = 1'b0;
        @(negedge clk);
        chk("stall_cnt sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        next();
`endif

        next();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 16-bit RISC core. Each cycle it computes the enable and clear for PC, IF_ID, ID_RR, RR_EX, EX_MEM and MEM_WB from memory stall, EX-stage redirect and load-use hazard conditions. It also sequences LM/SM (load/store-multiple) instructions held in ID into one micro-op per mask bit. It sits beside the datapath and drives every pipeline register's EN/CLR pins.

## Interface
Parameters:
- MASK_W, 8, width of the LM/SM register mask (id_ir[MASK_W-1:0]); bit i selects register Ri.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_ir  in  16  instruction in IF_ID (decode stage)
- ex_ir  in  16  instruction in RR_EX (execute stage)
- ex_dest  in  3  destination register of the EX instruction
- rr_src_a / rr_src_b  in  3  source registers of the RR-stage instruction
- rr_src_a_vld / rr_src_b_vld  in  1  source actually read
- ex_redirect  in  1  branch taken or jump resolved in EX
- mem_stall  in  1  data memory not ready
- pc_en, if_id_en, id_rr_en, rr_ex_en, ex_mem_en, mem_wb_en  out  1  register enables
- if_id_clr, id_rr_clr, rr_ex_clr, ex_mem_clr, mem_wb_clr  out  1  register clears (clear overrides enable in the registers)
- uop_valid  out  1  LM/SM micro-op issued into ID_RR this cycle
- uop_reg  out  3  register index of the micro-op
- uop_offset  out  16  byte offset from base, 0,2,4,...
- lmsm_busy  out  1  FSM in SEQ
- stall_cnt, flush_cnt  out  16  performance counters (see Configuration)

## Operation
- All enables and clears are combinational (Mealy) from registered FSM state plus the current inputs. They take effect at the next clk edge.
- Priority, highest first: rst > mem_stall > ex_redirect > load-use > LM/SM > normal.
- rst: all *_en=0, all *_clr=1, uop_valid=0, lmsm_busy=0. Next state is IDLE; mask register, offset and counters go to 0.
- mem_stall: PC, IF_ID, ID_RR, RR_EX and EX_MEM enables are 0, mem_wb_clr=1 (bubble), and the FSM is frozen.
- ex_redirect: if_id_clr, id_rr_clr and rr_ex_clr are 1, and all other enables are 1. Any LM/SM sequence is aborted and the FSM goes to IDLE.
- Load-use: ex_ir[15:12]==OP_LW and (rr_src_a_vld&&rr_src_a==ex_dest or rr_src_b_vld&&rr_src_b==ex_dest).
  - pc_en, if_id_en and id_rr_en are 0; rr_ex_clr=1; ex_mem_en and mem_wb_en are 1.
  - FSM frozen; the condition lasts exactly one cycle.
- Normal operation: all enables are 1 and all clears are 0.
- LM/SM FSM has two states, IDLE and SEQ.
- IDLE, with id_ir[15:12] ∈ {OP_LM, OP_SM}:
  - Mask zero: the instruction passes as a NOP (id_rr_clr=1 for one cycle), with no stall.
  - Mask nonzero: issue the lowest set bit this cycle (uop_valid=1, uop_reg=index, uop_offset=0).
  - If other bits remain: store the remaining mask, set offset=2, go to SEQ, and hold pc_en=if_id_en=0.
  - If no bits remain: stay in IDLE with normal enables.
- SEQ: issue the lowest set bit of the stored mask at the stored offset, clear that bit, and add 2 to offset. id_rr_en=1, pc_en=if_id_en=0.
- SEQ, last bit issued: pc_en=if_id_en=1 and the next state is IDLE.
- An LM/SM with k mask bits set occupies ID for k cycles (k−1 stall cycles).

## Timing
- Zero-cycle decision latency: outputs are valid in the same cycle as their inputs.
- The state register updates only when not frozen by rst, mem_stall or load-use.
- ex_redirect in the same cycle as the last SEQ issue: redirect wins, the micro-op is flushed (id_rr_clr=1, uop_valid=0), and the FSM goes to IDLE.
- rst mid-SEQ: the FSM goes to IDLE on the next edge and the remaining mask is discarded.
- uop_offset arithmetic is unsigned 16-bit. Maximum value is 2·(MASK_W−1), so it never wraps.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - stall_cnt increments each cycle in which pc_en=0 and rst=0.
  - flush_cnt increments each cycle in which ex_redirect is honoured.
  - Both counters are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Not defined: stall_cnt and flush_cnt are tied to 0, no counter flops are generated, and the ports remain.

## Structure
- Shared package pipe_pkg holds:
  - OP_LW=4'b0100, OP_SW=4'b0101, OP_LM=4'b0110, OP_SM=4'b0111
  - NOP_IR encoding
  - lmsm_state_t enum {IDLE, SEQ}
- Sub-module lsb_prio_enc: MASK_W-bit lowest-set-bit encoder that outputs the index, a found flag and the mask with that bit cleared. It is used for both the combinational first issue and SEQ issue.

## Test plan
- Reset: hold rst for 2 cycles → all *_clr=1, all *_en=0, and uop_valid=0 throughout. In the first cycle after release with neutral inputs, all *_en=1 and all *_clr=0.
- Load-use: ex_ir=16'h4A40 (LW, dest R5), ex_dest=5, rr_src_a=5 with rr_src_a_vld=1 → for exactly one cycle, pc_en=if_id_en=id_rr_en=0 and rr_ex_clr=1, then normal operation resumes.
- LM sequencing: id_ir opcode LM with mask 8'b1010_0100 → uop_reg sequence 2,5,7 with uop_offset 0,2,4 over 3 cycles. pc_en is low for the first 2 cycles and high in the third.
- Redirect abort: LM with mask 8'hFF, and ex_redirect asserted in the third issue cycle → if_id_clr=id_rr_clr=rr_ex_clr=1 and uop_valid=0 that cycle. lmsm_busy=0 next cycle.
- Memory stall mid-SEQ: mask 8'b0000_0011, mem_stall held for 3 cycles after the first issue → mem_wb_clr=1 and uop_reg remains 1 until the stall drops, then issues once and the FSM returns to IDLE.
- With PIPE_HAZARD_CTRL_PERF_EN: 70000 consecutive stall cycles → stall_cnt saturates at 16'hFFFF.
